// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the execute stage (radix-2, one step per cycle).
// Latency: start accepted in cycle T -> result_valid_o in T+33; divide-by-zero/overflow in T+1.
// Backpressure: stallreq_o holds ID/EX while busy; hold_i keeps the result presented in DONE.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      md_op_i,
    input  logic [XLEN-1:0] operand1_i,
    input  logic [XLEN-1:0] operand2_i,
    input  logic [4:0]      wreg_addr_i,
    input  logic            flush_i,
    input  logic            hold_i,
    output logic            stallreq_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o,
    output logic [4:0]      wreg_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [2:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_opnd;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_rem;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_result;
    logic              r_result_valid;
    logic [4:0]        r_wreg_addr;

    logic              w_is_div;
    logic              w_op1_signed;
    logic              w_op2_signed;
    logic              w_op1_neg;
    logic              w_op2_neg;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_neg_flag;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_accept;
    logic              w_last;

    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_acc_step;
    logic [XLEN-1:0]   w_rem_step;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_div_raw;
    logic [XLEN-1:0]   w_div_fix;
    logic [XLEN-1:0]   w_calc_res;

    // Decode the incoming instruction: signedness, magnitudes, result sign and the no-iteration cases.
    always_comb begin
        w_is_div     = md_op_i[2];
        w_op1_signed = (md_op_i == OP_MULH) || (md_op_i == OP_MULHSU) ||
                       (md_op_i == OP_DIV)  || (md_op_i == OP_REM);
        w_op2_signed = (md_op_i == OP_MULH) || (md_op_i == OP_DIV) || (md_op_i == OP_REM);
        w_op1_neg    = w_op1_signed & operand1_i[XLEN-1];
        w_op2_neg    = w_op2_signed & operand2_i[XLEN-1];
        w_abs1       = w_op1_neg ? (-operand1_i) : operand1_i;
        w_abs2       = w_op2_neg ? (-operand2_i) : operand2_i;
        // A remainder takes the dividend's sign; products and quotients take the XOR.
        w_neg_flag   = (md_op_i == OP_REM) ? w_op1_neg : (w_op1_neg ^ w_op2_neg);
        w_div_zero   = w_is_div && (operand2_i == '0);
        w_div_ovf    = ((md_op_i == OP_DIV) || (md_op_i == OP_REM)) &&
                       (operand1_i == INT_MIN) && (operand2_i == ALL_ONES);
        w_special    = w_div_zero || w_div_ovf;
        if (w_div_zero) begin
            w_special_res = md_op_i[1] ? operand1_i : ALL_ONES;
        end else begin
            w_special_res = md_op_i[1] ? '0 : INT_MIN;
        end
        w_accept = (r_state == S_IDLE) && start_i && !flush_i;
        w_last   = (r_cnt == LAST_CNT);
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
        w_shift    = {r_rem, r_acc[XLEN-1]};
        w_diff     = w_shift - {1'b0, r_opnd};
        w_acc_step = r_acc;
        w_rem_step = r_rem;
        if (r_op[2]) begin
            // Divide: r_acc[XLEN-1:0] shifts the dividend out and the quotient in.
            if (w_diff[XLEN]) begin
                w_rem_step = w_shift[XLEN-1:0];
                w_acc_step = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], 1'b0};
            end else begin
                w_rem_step = w_diff[XLEN-1:0];
                w_acc_step = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], 1'b1};
            end
        end else if (r_acc[0]) begin
            // Multiply: the multiplier sits in the low half and is consumed LSB first.
            w_acc_step = {w_sum, r_acc[XLEN-1:1]};
        end else begin
            w_acc_step = {1'b0, r_acc[2*XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection applied to the value of the final step.
    always_comb begin
        w_prod_fix = r_neg ? (-w_acc_step) : w_acc_step;
        w_div_raw  = r_op[1] ? w_rem_step : w_acc_step[XLEN-1:0];
        w_div_fix  = r_neg ? (-w_div_raw) : w_div_raw;
        case (r_op)
            OP_MUL:                       w_calc_res = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU,
            OP_REM, OP_REMU:              w_calc_res = w_div_fix;
            default:                      w_calc_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides start and hold from any state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!hold_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Operand latching, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op           <= '0;
            r_neg          <= 1'b0;
            r_opnd         <= '0;
            r_acc          <= '0;
            r_rem          <= '0;
            r_cnt          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_wreg_addr    <= '0;
        end else if (flush_i) begin
            r_cnt          <= '0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_op        <= md_op_i;
                        r_neg       <= w_neg_flag;
                        r_wreg_addr <= wreg_addr_i;
                        r_cnt       <= '0;
                        r_rem       <= '0;
                        // Low half holds the multiplier or dividend; r_opnd the multiplicand or divisor.
                        r_acc       <= {{XLEN{1'b0}}, (w_is_div ? w_abs1 : w_abs2)};
                        r_opnd      <= w_is_div ? w_abs2 : w_abs1;
                        if (w_special) begin
                            r_result       <= w_special_res;
                            r_result_valid <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_step;
                    r_rem <= w_rem_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result       <= w_calc_res;
                        r_result_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!hold_i) begin
                        r_result_valid <= 1'b0;
                    end
                end
                default: r_result_valid <= 1'b0;
            endcase
        end
    end

    assign stallreq_o     = ((r_state == S_IDLE) && start_i && !flush_i) ||
                            ((r_state == S_CALC) && !flush_i);
    assign result_o       = r_result;
    assign result_valid_o = r_result_valid;
    assign wreg_addr_o    = r_wreg_addr;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit inside the execute stage.
- Consumes the decoded instruction held in the ID/EX pipeline register (operands, write-register address) and returns a 32-bit result to EX for forwarding to EX/MEM.
- Raises a stall request to ctrl while busy, so ID/EX and earlier stages hold the instruction until the result is ready.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold values 0..XLEN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  EX presents a valid M-extension instruction this cycle
- md_op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- operand1_i  in  32  rs1 value (multiplicand/dividend)
- operand2_i  in  32  rs2 value (multiplier/divisor)
- wreg_addr_i  in  5  destination register
- flush_i  in  1  abort current operation (branch/trap flush)
- hold_i  in  1  EX/MEM stalled (stalled_i[3] stop); keep result presented
- stallreq_o  out  1  request pipeline stall to ctrl
- result_o  out  32  final result
- result_valid_o  out  1  result_o/wreg_addr_o valid this cycle
- wreg_addr_o  out  5  latched destination register

Behaviour:
- Reset (async, rst_n low): state IDLE, cnt 0, result_o 0x00000000, result_valid_o 0, wreg_addr_o 0, internal accumulators 0.
- States: IDLE, CALC, DONE.
- IDLE, start_i=1, flush_i=0:
  - latch md_op_i, wreg_addr_i and the absolute values of the operands per signedness (MULH/DIV/REM: both signed; MULHSU: op1 signed only; others unsigned);
  - latch the result sign (quotient/product sign = XOR of the operand signs; remainder sign = dividend sign).
- IDLE special cases (go straight to DONE, no iteration):
  - divisor 0: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU remainder = operand1_i.
  - DIV/REM with op1 0x80000000 and op2 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Otherwise go to CALC with cnt=0.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract over a 33-bit partial remainder.
  - cnt increments each cycle. After the step with cnt==31, apply sign fix-up (two's complement negate if the sign flag is set), register result_o, and go to DONE.
- Result selection:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: result_valid_o=1.
  - hold_i=1: stay in DONE, result_o stable.
  - hold_i=0: go to IDLE; start_i is ignored in DONE (it is the same held instruction).
- Latency:
  - start sampled at edge ending cycle T; iterative result_valid_o=1 in cycle T+33; special cases in cycle T+1.
  - Back-to-back: a new start is accepted in the cycle after DONE exits.
- stallreq_o is combinational: (state==IDLE & start_i & ~flush_i) | (state==CALC & ~flush_i). It is 0 in DONE, so the pipeline advances exactly when the result is valid.
- result_valid_o, result_o and wreg_addr_o are registered; result_valid_o is 0 in IDLE and CALC.
- flush_i=1 in any state:
  - next state IDLE, result_valid_o 0 next cycle, stallreq_o forced 0 in the same cycle;
  - in-flight result discarded; flush has priority over start_i and hold_i.
- Reset mid-CALC: immediate return to reset values; no partial result is ever presented.
- The unit never writes the register file directly; EX muxes result_o when result_valid_o=1.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), start at T -> stallreq_o=1 for T..T+32, result_valid_o=1 at T+33, result_o=0xFFFFFFEB, wreg_addr_o echoes input.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM same -> 0.
- flush_i at T+10 of a DIV -> stallreq_o=0 that cycle, IDLE next, no result_valid_o; new MUL at T+12 completes normally at T+45.
- hold_i=1 for 3 cycles in DONE -> result_valid_o and result_o stable 4 cycles, then IDLE; async rst_n pulse mid-CALC -> all outputs 0 immediately.
